// File: rtl/top.sv
// rtl/top.sv - UART 8N1 echo: RX deserializer feeds a byte FIFO that feeds a TX serializer
module top #(
  parameter int CLK_HZ       = 12000000,
  parameter int BAUD         = 115200,
  parameter int CLKS_PER_BIT = CLK_HZ / BAUD,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  output logic tx
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  logic          rx_meta_q, rx_sync_q;
  state_e        rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic          rx_ferr_q, rx_ferr_d;
  logic          rx_push;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [7:0]    mem_d [FIFO_DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic          fifo_empty, fifo_full, wr_en, rd_en;
  logic [7:0]    fifo_rdata;

  state_e        tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_shift_q, tx_shift_d;
  logic          tx_q, tx_d;
  logic          tx_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_ferr_q  <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
    end else begin
      rx_meta_q  <= rx;
      rx_sync_q  <= rx_meta_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_ferr_q  <= rx_ferr_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
    end
  end

  // RX next state; a framing error parks in STOP until the line returns high
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_ferr_d  = rx_ferr_q;
    case (rx_state_q)
      S_IDLE: begin
        rx_cnt_d  = '0;
        rx_bit_d  = '0;
        rx_ferr_d = 1'b0;
        if (!rx_sync_q) rx_state_d = S_START;
      end
      S_START: begin
        if (rx_cnt_q == HALF_END) begin
          rx_cnt_d   = '0;
          rx_state_d = rx_sync_q ? S_IDLE : S_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (rx_cnt_q == BIT_END) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        if (rx_ferr_q) begin
          if (rx_sync_q) rx_state_d = S_IDLE;
        end else if (rx_cnt_q == BIT_END) begin
          if (rx_sync_q) rx_state_d = S_IDLE;
          else           rx_ferr_d  = 1'b1;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rx_push = (rx_state_q == S_STOP) && !rx_ferr_q && (rx_cnt_q == BIT_END) && rx_sync_q;
  end

  // Extra pointer MSB distinguishes full from empty when the indices match
  always_comb begin
    fifo_empty = (wr_ptr_q == rd_ptr_q);
    fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    fifo_rdata = mem_q[rd_ptr_q[AW-1:0]];
    wr_en      = rx_push && !fifo_full;
    rd_en      = tx_pop && !fifo_empty;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (wr_en) begin
      mem_d[wr_ptr_q[AW-1:0]] = rx_shift_q;
      wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    end
    if (rd_en) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    case (tx_state_q)
      S_IDLE: begin
        tx_cnt_d = '0;
        tx_bit_d = '0;
        if (!fifo_empty) begin
          tx_shift_d = fifo_rdata;
          tx_state_d = S_START;
        end
      end
      S_START, S_STOP: begin
        if (tx_cnt_q == BIT_END) begin
          tx_cnt_d   = '0;
          tx_state_d = (tx_state_q == S_START) ? S_DATA : S_IDLE;
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (tx_cnt_q == BIT_END) begin
          tx_cnt_d   = '0;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          tx_bit_d   = tx_bit_q + 3'd1;
          if (tx_bit_q == 3'd7) tx_state_d = S_STOP;
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      default: tx_state_d = S_IDLE;
    endcase
  end

  // tx is registered from the next state so the line never glitches
  always_comb begin
    tx_pop = (tx_state_q == S_IDLE);
    case (tx_state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = tx_shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  assign tx = tx_q;

endmodule

// File: tb/tb_top.sv
// tb/tb_top.sv - directed and randomized echo checks of the UART echo top
`timescale 1ns/1ps
module tb_top;
  localparam int CPB    = 104;
  localparam int BIT_NS = 8680;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx = 1'b1;
  logic tx;
  int tests = 0;
  int fails = 0;

  top dut (.clk(clk), .rst_n(rst_n), .rx(rx), .tx(tx));

  always #41.667 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      #(BIT_NS);
    end
    rx = stop_bit;
    #(BIT_NS);
    rx = 1'b1;
  endtask

  // Decodes one tx frame, checking every completed level run is a whole number of bits
  task automatic recv_byte(input int budget, input string tag, output logic [7:0] b, output int start_len);
    int waited;
    int run;
    logic prev;
    logic [9:0] bits;
    waited = 0;
    b = '0;
    start_len = 0;
    bits = '0;
    while (tx !== 1'b0 && waited < budget) begin
      @(negedge clk);
      waited++;
    end
    if (tx !== 1'b0) begin
      check({tag, "_timeout"}, 32'(tx), 32'(0));
      return;
    end
    prev = 1'b0;
    run = 1;
    for (int c = 1; c < 10 * CPB; c++) begin
      @(negedge clk);
      if (tx !== prev) begin
        if (start_len == 0) start_len = run;
        check({tag, "_bitwidth"}, 32'(run >= CPB - 1 && (run % CPB <= 1 || run % CPB >= CPB - 1)), 32'(1));
        prev = tx;
        run = 1;
      end else begin
        run++;
      end
      if (c % CPB == CPB / 2) bits[c / CPB] = tx;
    end
    check({tag, "_startbit"}, 32'(bits[0]), 32'(0));
    check({tag, "_stopbit"}, 32'(bits[9]), 32'(1));
    b = bits[8:1];
  endtask

  task automatic no_echo(input int cycles, input string tag);
    int lows;
    lows = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    check(tag, 32'(lows), 32'(0));
  endtask

  initial begin
    logic [7:0] got;
    int sl;
    int waited;
    logic [7:0] seq3 [6];
    logic [7:0] rnd_b [8];
    logic       rnd_ok [8];
    logic [7:0] exp_q [$];

    seq3 = '{8'h00, 8'h11, 8'h01, 8'h02, 8'h03, 8'h04};

    repeat (5) @(negedge clk);
    check("reset_tx", 32'(tx), 32'(1));
    rst_n = 1'b1;

    no_echo(24000, "idle_2ms");

    fork
      send_byte(8'hFF, 1'b1);
      recv_byte(3000, "t2", got, sl);
    join
    check("t2_data", 32'(got), 32'hFF);
    check("t2_start_len", 32'(sl), 32'(CPB));

    fork
      for (int i = 0; i < 6; i++) send_byte(seq3[i], 1'b1);
      for (int i = 0; i < 6; i++) begin
        recv_byte(3000, "t3", got, sl);
        check("t3_data", 32'(got), 32'(seq3[i]));
      end
    join

    fork
      begin
        send_byte(8'h55, 1'b0);
        #(BIT_NS);
        send_byte(8'h3C, 1'b1);
      end
      begin
        recv_byte(4000, "t4", got, sl);
        check("t4_data", 32'(got), 32'h3C);
      end
    join
    no_echo(1500, "t4_no_extra");

    @(negedge clk);
    rx = 1'b0;
    repeat (20) @(negedge clk);
    rx = 1'b1;
    no_echo(2500, "t5_glitch");
    fork
      send_byte(8'h81, 1'b1);
      recv_byte(3000, "t5_after", got, sl);
    join
    check("t5_after_data", 32'(got), 32'h81);

    send_byte(8'hA5, 1'b1);
    waited = 0;
    while (tx !== 1'b0 && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    repeat (250) @(negedge clk);
    check("t6_mid_frame_low", 32'(tx), 32'(0));
    #20;
    rst_n = 1'b0;
    #1;
    check("t6_reset_tx", 32'(tx), 32'(1));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    no_echo(3000, "t6_residual");
    fork
      send_byte(8'h5A, 1'b1);
      recv_byte(3000, "t6_next", got, sl);
    join
    check("t6_next_data", 32'(got), 32'h5A);

    // Model: a frame echoes exactly when its stop bit is high, in arrival order
    for (int i = 0; i < 8; i++) begin
      rnd_b[i]  = 8'($urandom);
      rnd_ok[i] = ($urandom_range(0, 3) != 0);
      if (rnd_ok[i]) exp_q.push_back(rnd_b[i]);
    end
    fork
      for (int i = 0; i < 8; i++) begin
        send_byte(rnd_b[i], rnd_ok[i]);
        if (!rnd_ok[i]) #(BIT_NS);
      end
      while (exp_q.size() > 0) begin
        recv_byte(4000, "rnd", got, sl);
        check("rnd_data", 32'(got), 32'(exp_q.pop_front()));
      end
    join
    no_echo(1500, "rnd_no_extra");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
